spi_frame_rx: RTL and testbench

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/spi_frame_rx.sv | 181 ++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI mode-0 write-frame receiver with a one-entry holding buffer
//
// Purpose:
//   Receives 16-bit SPI frames (mode 0, MSB first) from raw pad signals that are
//   asynchronous to clk. Frame layout: bit15 = R/W (1 = write), bits14:8 = address,
//   bits7:0 = data. Complete write frames are handed to a register bank through a
//   one-entry valid/ready holding buffer. Read frames are dropped silently; frames
//   whose bit count is not 16 are dropped and flagged with a one-cycle error pulse.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   sclk       in   raw SPI clock from pad
//   copi       in   raw SPI data-in from pad
//   ncs        in   raw SPI chip select, active low
//   wr_valid   out  a complete write frame is held on wr_addr/wr_data
//   wr_addr    out  7-bit frame address field
//   wr_data    out  8-bit frame data field
//   wr_ready   in   downstream accepts the held frame this cycle
//   frame_err  out  one-cycle pulse: frame ended with a bit count other than 16
//   ovf        out  sticky: a valid write frame was dropped because the buffer was full

module spi_frame_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic       wr_ready,
   output logic       frame_err,
   output logic       ovf
);

   localparam logic [1:0] WAIT_IDLE = 2'd0;
   localparam logic [1:0] IDLE      = 2'd1;
   localparam logic [1:0] SHIFT     = 2'd2;

   localparam logic [4:0] FRAME_BITS = 5'd16;
   localparam logic [4:0] CNT_MAX    = 5'd17;

   // synchronizer chains: s1/s2 are the two metastability flops, prev is the edge-detect flop
   logic        sclk_s1, sclk_s2, sclk_prev;
   logic        copi_s1, copi_s2;
   logic        ncs_s1, ncs_s2, ncs_prev;

   logic [1:0]  settle;
   logic [1:0]  state;
   logic [15:0] shreg;
   logic [4:0]  bit_cnt;

   logic        sclk_rise;
   logic        ncs_fall;
   logic        ncs_rise;
   logic        settled;
   logic        frame_end;
   logic        frame_ok;
   logic        fwd;
   logic        consume;

   // ------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_s1   <= 1'b0;
         sclk_s2   <= 1'b0;
         sclk_prev <= 1'b0;
         copi_s1   <= 1'b0;
         copi_s2   <= 1'b0;
         ncs_s1    <= 1'b1;
         ncs_s2    <= 1'b1;
         ncs_prev  <= 1'b1;
      end else begin
         sclk_s1   <= sclk;
         sclk_s2   <= sclk_s1;
         sclk_prev <= sclk_s2;
         copi_s1   <= copi;
         copi_s2   <= copi_s1;
         ncs_s1    <= ncs;
         ncs_s2    <= ncs_s1;
         ncs_prev  <= ncs_s2;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_prev;
   assign ncs_fall  = ~ncs_s2 & ncs_prev;
   assign ncs_rise  = ncs_s2 & ~ncs_prev;

   // The ncs chain comes out of reset preset high, so right after reset ncs_s2
   // reports "deselected" no matter what the pin does. Leaving WAIT_IDLE on that
   // stale value would let a chip select that was already low at reset release
   // look like a fresh falling edge. Hold in WAIT_IDLE until the chain has been
   // refilled from the pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle <= 2'd0;
      end else if (!settle[1]) begin
         settle <= settle + 2'd1;
      end
   end

   assign settled = settle[1];

   // ------------------------------------------------------------------
   // Frame FSM, shift register and bit counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= WAIT_IDLE;
         shreg   <= 16'd0;
         bit_cnt <= 5'd0;
      end else begin
         case (state)
            WAIT_IDLE: begin
               if (settled && ncs_s2) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (ncs_fall) begin
                  state   <= SHIFT;
                  shreg   <= 16'd0;
                  bit_cnt <= 5'd0;
               end
            end
            SHIFT: begin
               if (ncs_rise) begin
                  state <= IDLE;
               end else if (sclk_rise) begin
                  shreg <= {shreg[14:0], copi_s2};
                  // saturate so an over-long frame can never wrap back to 16
                  if (bit_cnt != CNT_MAX) begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
            default: begin
               state <= WAIT_IDLE;
            end
         endcase
      end
   end

   assign frame_end = (state == SHIFT) && ncs_rise;
   assign frame_ok  = (bit_cnt == FRAME_BITS);
   assign fwd       = frame_end && frame_ok && shreg[15];
   assign consume   = wr_valid && wr_ready;

   // ------------------------------------------------------------------
   // Error pulse, holding buffer and overflow flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= 7'd0;
         wr_data   <= 8'd0;
         ovf       <= 1'b0;
      end else begin
         frame_err <= frame_end && !frame_ok;

         // a slot freed by a same-cycle consume can be refilled immediately
         if (fwd && (!wr_valid || wr_ready)) begin
            wr_valid <= 1'b1;
            wr_addr  <= shreg[14:8];
            wr_data  <= shreg[7:0];
         end else begin
            if (consume) begin
               wr_valid <= 1'b0;
            end
            if (fwd) begin
               ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - self-checking bench for spi_frame_rx with a frame-level reference model

module tb_spi_frame_rx;

   logic       clk;
   logic       rst;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic       wr_ready;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_err;
   logic       ovf;

   spi_frame_rx dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .copi      (copi),
      .ncs       (ncs),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .frame_err (frame_err),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: frames are whole events, resolved at the edge where
   // their result must become visible (third clk edge after ncs rises).
   // ------------------------------------------------------------------
   typedef struct {
      int          due;
      int          nbits;
      logic [31:0] val;
   } ev_t;

   ev_t        evq[$];
   int         cyc = 0;
   int         last_due = 0;
   logic       m_valid = 1'b0;
   logic [6:0] m_addr = 7'd0;
   logic [7:0] m_data = 8'd0;
   logic       m_ovf = 1'b0;
   logic       m_err = 1'b0;

   initial begin
      ev_t ev;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_valid = 1'b0;
            m_addr  = 7'd0;
            m_data  = 8'd0;
            m_ovf   = 1'b0;
            m_err   = 1'b0;
            evq.delete();
         end else begin
            cyc++;
            m_err = 1'b0;
            if (m_valid && wr_ready) m_valid = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
               ev = evq.pop_front();
               if (ev.nbits != 16) begin
                  m_err = 1'b1;
               end else if (ev.val[15]) begin
                  if (!m_valid) begin
                     m_valid = 1'b1;
                     m_addr  = ev.val[14:8];
                     m_data  = ev.val[7:0];
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
            end
         end
      end
   end

   // cycle-by-cycle comparison against the model
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("wr_valid", wr_valid, m_valid);
         check("frame_err", frame_err, m_err);
         check("ovf", ovf, m_ovf);
         if (m_valid) begin
            check("wr_addr", wr_addr, m_addr);
            check("wr_data", wr_data, m_data);
         end
      end
   end

   // event counters used by the hand-computed expectations
   int         n_valid = 0;
   int         n_err = 0;
   int         n_acc = 0;
   logic [6:0] last_addr = 7'd0;
   logic [7:0] last_data = 8'd0;

   initial begin
      forever begin
         @(negedge clk);
         if (wr_valid === 1'b1) begin
            n_valid++;
            last_addr = wr_addr;
            last_data = wr_data;
            if (wr_ready === 1'b1) n_acc++;
         end
         if (frame_err === 1'b1) n_err++;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   logic rand_ready = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input int n, input logic [31:0] val);
      for (int i = n - 1; i >= 0; i--) begin
         copi = val[i];
         tick(3);
         sclk = 1'b1;
         tick(3);
         sclk = 1'b0;
      end
      tick(3);
   endtask

   task automatic send_frame(input int n, input logic [31:0] val, input int gap);
      ev_t ev;
      ncs = 1'b0;
      tick(3);
      send_bits(n, val);
      ncs = 1'b1;
      ev.due   = cyc + 3;
      ev.nbits = n;
      ev.val   = val;
      last_due = ev.due;
      evq.push_back(ev);
      tick(gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(6);
   endtask

   initial begin
      int sv;
      int se;
      int sa;
      int guard;
      int nb;
      logic [31:0] rv;

      rst = 1'b1;
      sclk = 1'b0;
      copi = 1'b0;
      ncs = 1'b1;
      wr_ready = 1'b0;
      tick(3);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick(6);

      // single write, downstream always ready
      wr_ready = 1'b1;
      sv = n_valid; se = n_err;
      send_frame(16, 32'h8155, 8);
      check("w8155_valid_cycles", n_valid - sv, 1);
      check("w8155_addr", last_addr, 7'h01);
      check("w8155_data", last_data, 8'h55);
      check("w8155_err", n_err - se, 0);

      // read frame, short frame, long frame
      sv = n_valid; se = n_err;
      send_frame(16, 32'h0042, 6);
      check("read_err", n_err - se, 0);
      send_frame(15, 32'h40AA, 6);
      send_frame(17, 32'h18155, 8);
      check("bad_len_err_pulses", n_err - se, 2);
      check("bad_len_valid", n_valid - sv, 0);

      // new frame lands in the same cycle the held one is consumed
      do_reset();
      wr_ready = 1'b0;
      sa = n_acc;
      send_frame(16, 32'h8123, 6);
      send_frame(16, 32'h8456, 0);
      guard = 0;
      while (cyc < last_due - 1 && guard < 10) begin
         tick(1);
         guard++;
      end
      check("coincide_timing", cyc, last_due - 1);
      wr_ready = 1'b1;
      tick(1);
      wr_ready = 1'b0;
      tick(2);
      check("coincide_valid", wr_valid, 1);
      check("coincide_addr", wr_addr, 7'h04);
      check("coincide_data", wr_data, 8'h56);
      check("coincide_ovf", ovf, 0);
      check("coincide_accepts", n_acc - sa, 1);

      // overflow with downstream stalled
      do_reset();
      wr_ready = 1'b0;
      sa = n_acc;
      send_frame(16, 32'h8211, 6);
      send_frame(16, 32'h83AA, 6);
      check("ovf_valid", wr_valid, 1);
      check("ovf_addr", wr_addr, 7'h02);
      check("ovf_data", wr_data, 8'h11);
      check("ovf_flag", ovf, 1);
      wr_ready = 1'b1;
      tick(4);
      check("ovf_accepts", n_acc - sa, 1);
      check("ovf_drained", wr_valid, 0);
      check("ovf_sticky", ovf, 1);

      // reset in the middle of a frame with ncs held low through release
      do_reset();
      wr_ready = 1'b0;
      sv = n_valid; se = n_err;
      ncs = 1'b0;
      tick(3);
      send_bits(8, 32'hA5);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      send_bits(8, 32'h3C);
      ncs = 1'b1;
      tick(8);
      check("abort_err", n_err - se, 0);
      check("abort_valid", n_valid - sv, 0);
      send_frame(16, 32'h8407, 6);
      check("after_abort_valid", wr_valid, 1);
      check("after_abort_addr", wr_addr, 7'h04);
      check("after_abort_data", wr_data, 8'h07);

      // randomized frames and backpressure
      do_reset();
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
         rv = $urandom;
         send_frame(nb, rv, int'($urandom_range(2, 6)));
      end
      rand_ready = 1'b0;
      tick(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
